dac_i2s_tx: RTL and testbench
=============================

Name: dac_i2s_tx

Overview:
- I2S transmitter for the cartridge audio DAC. Serialises 16-bit stereo PCM samples onto dac_mclk/dac_sclk/dac_lrck/dac_sdin.
- Replaces the fixed-zero "mute" drive used in the system mapper with real sample output.
- Sits between a sample producer (mapper audio mixer, MCD/SMS core) and the DAC pins.
- Accepts samples through a valid/ready handshake into a one-deep holding register. Latches them once per frame.

Parameters:
SMP_W, 16, sample width per channel (1..31), sent MSB first.
UND_HOLD, 1, 1 = repeat the previous frame's sample on underrun; 0 = send zero on underrun.

Ports:
clk  in  1  system clock; all logic on negedge clk (same edge as the other mapper logic)
sys_rst  in  1  asynchronous, active-high reset
en  in  1  0 = clocks stopped, counter held at 0, all DAC outputs 0
mute  in  1  1 = clocks keep running, sdin forced 0, samples still consumed
snd_l  in  SMP_W  left sample (two's complement)
snd_r  in  SMP_W  right sample
snd_valid  in  1  producer holds snd_l/snd_r
snd_ready  out  1  holding register can accept a pair
dac_mclk  out  1  ctr[1] (clk/4)
dac_sclk  out  1  ctr[3] (clk/16, 64 sclk per frame)
dac_lrck  out  1  ctr[9] (0 = left half, 1 = right half; clk/1024)
dac_sdin  out  1  serial data, registered
frame_stb  out  1  1-cycle pulse on each frame load
underrun  out  1  1-cycle pulse when a frame loads with the holding register empty

Behaviour:
- Reset values: ctr=0; holding empty; shadow_l=shadow_r=0; snd_ready=1; all DAC outputs 0; frame_stb=0; underrun=0.
- Counter: 10-bit ctr increments every clk while en=1 and wraps 1023->0. When en=0, ctr=0 the next cycle.
- Derived outputs: mclk/sclk/lrck come straight from ctr bits, so they are glitch-free register outputs.
- Slot index: slot = ctr[8:4] (0..31) within each lrck half. The channel is selected by ctr[9].
- sdin update timing: sdin is updated in the cycle where ctr[3:0]==15, computed for the *next* ctr value. It therefore changes together with the sclk falling edge and is stable at sclk rising.
- sdin slot mapping (I2S 1-bit delay):
  - slot 0 -> 0
  - slots 1..SMP_W -> sample[SMP_W-slot]
  - slots SMP_W+1..31 -> 0
- Frame load: happens in the cycle where ctr==1023 and en=1.
  - Holding full -> shadow<=holding, holding freed.
  - Holding empty and snd_valid=1 -> shadow<=snd_l/snd_r directly (bypass), no underrun.
  - Holding empty and snd_valid=0 -> underrun pulse; shadow keeps its value (UND_HOLD=1) or is cleared to 0 (UND_HOLD=0).
  - frame_stb pulses on every load.
- Handshake:
  - Transfer occurs when snd_valid & snd_ready.
  - snd_ready = holding empty OR load cycle with holding full (the slot is freed the same cycle, so the new pair enters holding).
  - After a transfer into holding outside a load cycle, snd_ready=0 the next cycle.
  - snd_l/snd_r are only sampled on transfer.
- mute=1: sdin is held 0. Loads, the handshake and underrun pulses are unchanged.
- en deassert mid-frame:
  - Next cycle: ctr=0 and mclk/sclk/lrck/sdin=0.
  - Holding and shadow are retained; no frame_stb.
  - On re-enable, output restarts at the left half, slot 0, using the retained shadow.
  - The first load occurs after 1024 cycles.
- sys_rst mid-frame: immediate clear to reset values; any in-flight holding data is discarded.

Decomposition:
- Constants go in the shared defs file: DAC_CTR_W=10, DAC_MCLK_BIT=1, DAC_SCLK_BIT=3, DAC_LRCK_BIT=9. These are reused by any mapper that mutes or drives the DAC.
- One natural sub-module: dac_clkgen (counter plus mclk/sclk/lrck plus load/update strobes). dac_i2s_tx holds the holding/shadow registers and the serialiser.

Test Plan:
1. Reset, en=1, no valid -> snd_ready=1; underrun pulses at cycle 1024, then every 1024 cycles; sdin=0 throughout (UND_HOLD either value, shadow=0).
2. Push L=16'hA5C3, R=16'h0001 before the first load -> at frame 2:
   - left slots 1..16 give 1010_0101_1100_0011; slot 0 and slots 17..31 give 0.
   - right slots 1..16 give 0x0001 (only slot 16 high).
   - frame_stb fires once per frame and sdin changes only when ctr[3:0] wraps 15->0.
3. Hold snd_valid=1 continuously with incrementing data -> exactly one transfer per 1024 cycles after the first fill; no underrun; snd_ready high only on the load cycle.
4. Holding empty, snd_valid asserted exactly in the ctr==1023 cycle with L=16'h8000 -> bypass load; no underrun; left slot 1=1; holding still empty afterwards.
5. mute=1 with valid data flowing -> sdin constant 0, lrck period 1024 clk, handshake continues; mute=0 restores data at the next slot boundary.
6. Drop en at ctr=300, raise again 50 cycles later -> outputs 0 the next cycle; restart at ctr=0 replaying the retained shadow; assert sys_rst mid-frame -> all outputs 0 immediately and snd_ready=1.

Source files
------------

// File: rtl/dac_i2s_tx_pkg.sv
// Shared DAC definitions: counter geometry, clock tap positions and the
// slot-to-bit mapping used by the I2S serialiser.
package dac_i2s_tx_pkg;

  localparam int DAC_CTR_W    = 10;
  localparam int DAC_MCLK_BIT = 1;
  localparam int DAC_SCLK_BIT = 3;
  localparam int DAC_LRCK_BIT = 9;
  localparam int DAC_SLOT_W   = DAC_LRCK_BIT - DAC_SCLK_BIT - 1;

  // I2S one-bit delay: slot 0 is idle, slots 1..w carry the sample MSB
  // first, anything past the sample width pads with zero.
  function automatic logic dac_slot_bit(input logic [31:0] smp,
                                        input logic [5:0] w,
                                        input logic [DAC_SLOT_W-1:0] slot);
    logic [5:0] idx;
    idx = w - {1'b0, slot};
    if (slot == '0 || {1'b0, slot} > w) begin
      return 1'b0;
    end
    return smp[idx[4:0]];
  endfunction

endpackage

// File: rtl/dac_i2s_tx_if.sv
// Sample handshake between an audio producer and the DAC transmitter.
interface dac_i2s_tx_if #(parameter int SMP_W = 16);

  logic [SMP_W-1:0] snd_l;
  logic [SMP_W-1:0] snd_r;
  logic             snd_valid;
  logic             snd_ready;

  modport master (output snd_l, output snd_r, output snd_valid, input snd_ready);
  modport slave  (input snd_l, input snd_r, input snd_valid, output snd_ready);

endinterface

// File: rtl/dac_i2s_tx_clkgen.sv
// Frame counter for the DAC: derives mclk/sclk/lrck directly from counter
// bits and produces the frame-load and data-update strobes.
module dac_i2s_tx_clkgen
  import dac_i2s_tx_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  output logic                  mclk_o,
  output logic                  sclk_o,
  output logic                  lrck_o,
  output logic                  load_o,
  output logic                  upd_o,
  output logic [DAC_SLOT_W-1:0] nxtSlot_o,
  output logic                  nxtRight_o
);

  localparam logic [DAC_CTR_W-1:0] CTR_ONE = DAC_CTR_W'(1);

  logic [DAC_CTR_W-1:0] ctr_q;
  logic [DAC_CTR_W-1:0] ctr_d;
  logic [DAC_CTR_W-1:0] ctrInc;

  assign ctrInc = ctr_q + CTR_ONE;

  // Free-running while enabled, parked at zero otherwise.
  always_comb begin
    ctr_d = '0;
    if (en_i) begin
      ctr_d = ctrInc;
    end
  end

  // Counter register, on the falling clock edge like the rest of the mapper.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign mclk_o     = ctr_q[DAC_MCLK_BIT];
  assign sclk_o     = ctr_q[DAC_SCLK_BIT];
  assign lrck_o     = ctr_q[DAC_LRCK_BIT];
  assign load_o     = en_i & (ctr_q == '1);
  assign upd_o      = en_i & (ctr_q[DAC_SCLK_BIT:0] == '1);
  assign nxtSlot_o  = ctrInc[DAC_LRCK_BIT-1:DAC_SCLK_BIT+1];
  assign nxtRight_o = ctrInc[DAC_LRCK_BIT];

endmodule

// File: rtl/dac_i2s_tx.sv
// I2S transmitter for the cartridge audio DAC: one-deep holding register
// fed by a valid/ready handshake, a per-frame shadow pair and the serialiser.
module dac_i2s_tx
  import dac_i2s_tx_pkg::*;
#(
  parameter int SMP_W    = 16,
  parameter bit UND_HOLD = 1'b1
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       en,
  input  logic       mute,
  dac_i2s_tx_if.slave snd,
  output logic       dac_mclk,
  output logic       dac_sclk,
  output logic       dac_lrck,
  output logic       dac_sdin,
  output logic       frame_stb,
  output logic       underrun
);

  logic                  load;
  logic                  upd;
  logic [DAC_SLOT_W-1:0] nxtSlot;
  logic                  nxtRight;
  logic                  xfer;
  logic                  nxtBit;

  logic             holdFull_q;
  logic [SMP_W-1:0] holdL_q;
  logic [SMP_W-1:0] holdR_q;
  logic [SMP_W-1:0] shadowL_q;
  logic [SMP_W-1:0] shadowR_q;
  logic             frameStb_q;
  logic             underrun_q;
  logic             sdin_q;

  dac_i2s_tx_clkgen u_clkgen (
    .clk_i      (clk),
    .rst_i      (sys_rst),
    .en_i       (en),
    .mclk_o     (dac_mclk),
    .sclk_o     (dac_sclk),
    .lrck_o     (dac_lrck),
    .load_o     (load),
    .upd_o      (upd),
    .nxtSlot_o  (nxtSlot),
    .nxtRight_o (nxtRight)
  );

  // A full holding slot is freed on the load cycle, so it can refill at once.
  assign snd.snd_ready = ~holdFull_q | load;
  assign xfer          = snd.snd_valid & snd.snd_ready;

  // Holding/shadow pair: load once per frame, bypass straight into the shadow
  // when a pair arrives exactly on an empty load cycle, flag underruns.
  always_ff @(negedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      holdFull_q <= 1'b0;
      holdL_q    <= '0;
      holdR_q    <= '0;
      shadowL_q  <= '0;
      shadowR_q  <= '0;
      frameStb_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      frameStb_q <= load;
      underrun_q <= load & ~holdFull_q & ~snd.snd_valid;
      if (load) begin
        if (holdFull_q) begin
          shadowL_q  <= holdL_q;
          shadowR_q  <= holdR_q;
          holdFull_q <= xfer;
          if (xfer) begin
            holdL_q <= snd.snd_l;
            holdR_q <= snd.snd_r;
          end
        end else if (snd.snd_valid) begin
          shadowL_q <= snd.snd_l;
          shadowR_q <= snd.snd_r;
        end else if (!UND_HOLD) begin
          shadowL_q <= '0;
          shadowR_q <= '0;
        end
      end else if (xfer) begin
        holdL_q    <= snd.snd_l;
        holdR_q    <= snd.snd_r;
        holdFull_q <= 1'b1;
      end
    end
  end

  assign nxtBit = dac_slot_bit(nxtRight ? 32'(shadowR_q) : 32'(shadowL_q),
                               6'(SMP_W), nxtSlot);

  // Serial data register: moves with the sclk falling edge, so it is settled
  // well before the DAC samples on sclk rising.
  always_ff @(negedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      sdin_q <= 1'b0;
    end else if (!en) begin
      sdin_q <= 1'b0;
    end else if (upd) begin
      sdin_q <= mute ? 1'b0 : nxtBit;
    end
  end

  assign dac_sdin  = sdin_q;
  assign frame_stb = frameStb_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Directed bench for dac_i2s_tx: frame timing, slot mapping, handshake,
// bypass load, mute, enable drop and reset.
module tb_dac_i2s_tx;

  logic        clk = 1'b1;
  logic        rst;
  logic        en;
  logic        mute;
  logic        dacMclk;
  logic        dacSclk;
  logic        dacLrck;
  logic        dacSdin;
  logic        frameStb;
  logic        underrunO;

  int          compareCount = 0;
  int          mismatchCount = 0;
  logic [9:0]  tbCtr = '0;
  int          stbCount, stbBad, undCount, sdinOnes, sdinBadChg, clkBad;
  int          readyCount, xferCount;
  logic [31:0] leftW, rightW;
  logic        prevSdin;
  bit          streamOn = 1'b0;
  logic [15:0] dataL, dataR;

  always #5 clk = ~clk;

  dac_i2s_tx_if #(.SMP_W(16)) sndIf ();

  dac_i2s_tx #(.SMP_W(16), .UND_HOLD(1'b1)) dut (
    .clk       (clk),
    .sys_rst   (rst),
    .en        (en),
    .mute      (mute),
    .snd       (sndIf),
    .dac_mclk  (dacMclk),
    .dac_sclk  (dacSclk),
    .dac_lrck  (dacLrck),
    .dac_sdin  (dacSdin),
    .frame_stb (frameStb),
    .underrun  (underrunO)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r);
    sndIf.snd_valid = v;
    sndIf.snd_l     = l;
    sndIf.snd_r     = r;
  endtask

  // One clock: note whether the coming falling edge transfers, then advance
  // the bench's own frame counter; outputs are read at posedge + 1.
  task automatic tick();
    logic willXfer;
    #1;
    willXfer = sndIf.snd_valid & sndIf.snd_ready;
    @(posedge clk);
    if (rst || !en) tbCtr = '0;
    else            tbCtr = tbCtr + 10'd1;
    if (willXfer) begin
      xferCount++;
      if (streamOn) begin
        dataL = dataL + 16'd1;
        dataR = dataR + 16'd1;
        applyStimulus(1'b1, dataL, dataR);
      end
    end
    #1;
  endtask

  task automatic tickUntil(input logic [9:0] target);
    for (int i = 0; i < 1100 && tbCtr != target; i++) tick();
  endtask

  // Run whole frames, gathering statistics and the last frame's slot words.
  task automatic runFrames(input int n);
    stbCount = 0; stbBad = 0; undCount = 0; sdinOnes = 0; sdinBadChg = 0;
    clkBad = 0; readyCount = 0; xferCount = 0; leftW = '0; rightW = '0;
    prevSdin = dacSdin;
    for (int i = 0; i < n * 1024; i++) begin
      tick();
      if ({dacMclk, dacSclk, dacLrck} !== {tbCtr[1], tbCtr[3], tbCtr[9]}) clkBad++;
      if (frameStb) begin
        stbCount++;
        if (tbCtr != 10'd0) stbBad++;
      end
      if (underrunO) undCount++;
      if (dacSdin) sdinOnes++;
      if (dacSdin !== prevSdin && tbCtr[3:0] != 4'd0) sdinBadChg++;
      prevSdin = dacSdin;
      if (tbCtr[3:0] == 4'd8) begin
        if (tbCtr[9]) rightW = {rightW[30:0], dacSdin};
        else          leftW  = {leftW[30:0], dacSdin};
      end
      if (sndIf.snd_ready) readyCount++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mute = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    checkOutput("reset_state",
                {25'd0, sndIf.snd_ready, dacMclk, dacSclk, dacLrck, dacSdin, frameStb, underrunO},
                32'b1000000);

    // Idle producer: an underrun every frame, silent output.
    rst = 1'b0; en = 1'b1;
    runFrames(3);
    checkOutput("t1_underruns", undCount, 3);
    checkOutput("t1_stb_count", stbCount, 3);
    checkOutput("t1_stb_pos", stbBad, 0);
    checkOutput("t1_sdin_zero", sdinOnes, 0);
    checkOutput("t1_clocks", clkBad, 0);
    checkOutput("t1_ready", readyCount, 3072);

    // Single pair before the load, then two frames of output.
    applyStimulus(1'b1, 16'hA5C3, 16'h0001);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("t2_ready_full", sndIf.snd_ready, 0);
    tickUntil(10'd0);
    checkOutput("t2_load", {30'd0, frameStb, underrunO}, 32'b10);
    checkOutput("t2_ready_freed", sndIf.snd_ready, 1);
    runFrames(1);
    checkOutput("t2_left", leftW, 32'h52E1_8000);
    checkOutput("t2_right", rightW, 32'h0000_8000);
    checkOutput("t2_stb_count", stbCount, 1);
    checkOutput("t2_stb_pos", stbBad, 0);
    checkOutput("t2_sdin_edges", sdinBadChg, 0);
    checkOutput("t2_clocks", clkBad, 0);
    checkOutput("t2_underrun", undCount, 1);
    runFrames(1);
    checkOutput("t2_hold_replay", leftW, 32'h52E1_8000);

    // Continuous producer: one transfer per frame, ready only on load.
    streamOn = 1'b1; dataL = 16'h1000; dataR = 16'h2000;
    applyStimulus(1'b1, dataL, dataR);
    runFrames(3);
    streamOn = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("t3_xfers", xferCount, 4);
    checkOutput("t3_ready", readyCount, 3);
    checkOutput("t3_underrun", undCount, 0);
    checkOutput("t3_stb_count", stbCount, 3);
    checkOutput("t3_left", leftW, 32'h0800_8000);
    checkOutput("t3_right", rightW, 32'h1000_8000);

    // Bypass: empty holding, pair offered exactly on the load cycle.
    runFrames(1);
    tickUntil(10'd1023);
    applyStimulus(1'b1, 16'h8000, 16'h7FFF);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("t4_bypass_load", {30'd0, frameStb, underrunO}, 32'b10);
    checkOutput("t4_hold_empty", sndIf.snd_ready, 1);
    runFrames(1);
    checkOutput("t4_left", leftW, 32'h4000_0000);
    checkOutput("t4_right", rightW, 32'h3FFF_8000);
    checkOutput("t4_underrun", undCount, 1);

    // Mute while data keeps flowing, then unmute.
    mute = 1'b1; streamOn = 1'b1; dataL = 16'hF0F0; dataR = 16'h0F0F;
    applyStimulus(1'b1, dataL, dataR);
    runFrames(2);
    checkOutput("t5_sdin_muted", sdinOnes, 0);
    checkOutput("t5_xfers", xferCount, 3);
    checkOutput("t5_underrun", undCount, 0);
    checkOutput("t5_clocks", clkBad, 0);
    mute = 1'b0;
    runFrames(1);
    streamOn = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("t5_left", leftW, 32'h7878_8000);
    checkOutput("t5_right", rightW, 32'h0788_0000);

    // Enable drop mid-frame: outputs off, state retained, replay on restart.
    tickUntil(10'd300);
    en = 1'b0;
    tick();
    checkOutput("t6_outputs_off", {28'd0, dacMclk, dacSclk, dacLrck, dacSdin}, 0);
    checkOutput("t6_no_stb", frameStb, 0);
    checkOutput("t6_hold_kept", sndIf.snd_ready, 0);
    repeat (49) tick();
    checkOutput("t6_still_off", {28'd0, dacMclk, dacSclk, dacLrck, dacSdin}, 0);
    en = 1'b1;
    runFrames(1);
    checkOutput("t6_left", leftW, 32'h7879_0000);
    checkOutput("t6_right", rightW, 32'h0788_8000);
    checkOutput("t6_stb_count", stbCount, 1);
    checkOutput("t6_stb_pos", stbBad, 0);
    checkOutput("t6_underrun", undCount, 0);

    // Reset mid-frame with a pair parked in holding.
    tickUntil(10'd600);
    applyStimulus(1'b1, 16'h1234, 16'h5678);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("t6_pre_reset", {28'd0, sndIf.snd_ready, dacLrck, dacSclk, dacSdin}, 32'b0111);
    rst = 1'b1;
    #1;
    checkOutput("t6_reset_async",
                {25'd0, sndIf.snd_ready, dacMclk, dacSclk, dacLrck, dacSdin, frameStb, underrunO},
                32'b1000000);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
